// File: rtl/reg_file_sb_if.sv
// Writeback, operand-read and issue/scoreboard signals of the vcpu1 register file.
// The master drives requests (decode/writeback side); the slave is the register file.
interface reg_file_sb_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          re1;
    logic          re2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          issue;
    logic          issue_wr;
    logic [AW-1:0] issue_waddr;
    logic          stall;
    logic          issued;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, re1, re2,
        output issue, issue_wr, issue_waddr,
        input  rdata1, rdata2, stall, issued
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, re1, re2,
        input  issue, issue_wr, issue_waddr,
        output rdata1, rdata2, stall, issued
    );
endinterface

// File: rtl/reg_file_sb.sv
// vcpu1 architectural register file: one synchronous write port, two bypassed combinational
// read ports, and a pending-write scoreboard that stalls issue on RAW/WAW hazards.
module reg_file_sb #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 5,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [NREG-1:0] eff_pend;
    logic            stall_c;
    logic            issued_c;
    logic            wr_en;
    logic            set_en;
    logic [DW-1:0]   rdata1_c;
    logic [DW-1:0]   rdata2_c;

    assign wr_en = bus.we && !(ZERO_R0 && bus.waddr == '0);

    // A register being written back this cycle is already considered ready.
    always_comb begin
        eff_pend = pend_q;
        if (bus.we) eff_pend[bus.waddr] = 1'b0;
    end

    always_comb begin
        stall_c = 1'b0;
        if (rst_n && bus.issue) begin
            stall_c = (bus.re1      && eff_pend[bus.raddr1])
                   || (bus.re2      && eff_pend[bus.raddr2])
                   || (bus.issue_wr && eff_pend[bus.issue_waddr]);
        end
    end

    assign issued_c = bus.issue && !stall_c;
    assign set_en   = issued_c && bus.issue_wr && !(ZERO_R0 && bus.issue_waddr == '0);

    always_comb begin
        rdata1_c = '0;
        if (!rst_n || (ZERO_R0 && bus.raddr1 == '0)) rdata1_c = '0;
        else if (bus.we && bus.waddr == bus.raddr1)  rdata1_c = bus.wdata;
        else                                         rdata1_c = regs_q[bus.raddr1];
    end

    always_comb begin
        rdata2_c = '0;
        if (!rst_n || (ZERO_R0 && bus.raddr2 == '0)) rdata2_c = '0;
        else if (bus.we && bus.waddr == bus.raddr2)  rdata2_c = bus.wdata;
        else                                         rdata2_c = regs_q[bus.raddr2];
    end

    assign bus.rdata1 = rdata1_c;
    assign bus.rdata2 = rdata2_c;
    assign bus.stall  = stall_c;
    assign bus.issued = issued_c;

    // Set is applied after clear so a same-cycle issue to the retiring register stays pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_en)  regs_d[bus.waddr]       = bus.wdata;
        if (bus.we) pend_d[bus.waddr]       = 1'b0;
        if (set_en) pend_d[bus.issue_waddr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end
endmodule
